// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter.
// slave: counter side; master: driver side.
// Inputs to counter: enable, countDirection, saturate (COUNTER_SAT_EN),
//   load, loadValue, clearWrap.
// Outputs from counter: counterOut, step, wrap, wrapFlag.
interface updown_mod_counter_if #(
    parameter int COUNTER_SIZE = 4
);
    logic                    enable;
    logic                    countDirection;
`ifdef COUNTER_SAT_EN
    logic                    saturate;
`endif
    logic                    load;
    logic [COUNTER_SIZE-1:0] loadValue;
    logic                    clearWrap;
    logic [COUNTER_SIZE-1:0] counterOut;
    logic                    step;
    logic                    wrap;
    logic                    wrapFlag;

    modport slave (
        input  enable,
        input  countDirection,
`ifdef COUNTER_SAT_EN
        input  saturate,
`endif
        input  load,
        input  loadValue,
        input  clearWrap,
        output counterOut,
        output step,
        output wrap,
        output wrapFlag
    );

    modport master (
        output enable,
        output countDirection,
`ifdef COUNTER_SAT_EN
        output saturate,
`endif
        output load,
        output loadValue,
        output clearWrap,
        input  counterOut,
        input  step,
        input  wrap,
        input  wrapFlag
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with prescaler, parallel load, wrap pulse, sticky flag.
// Ports: clk, rst (sync, active-high), bus (updown_mod_counter_if.slave).
// Optional: define COUNTER_SAT_EN to add bus.saturate (hold at boundary).
module updown_mod_counter #(
    parameter int COUNTER_SIZE = 4,
    parameter int MOD_VALUE    = 2 ** COUNTER_SIZE,
    parameter int PRESCALE     = 1
) (
    input  logic                clk,
    input  logic                rst,
    updown_mod_counter_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);
    localparam logic [COUNTER_SIZE-1:0] MAXV = COUNTER_SIZE'(MOD_VALUE - 1);

    logic [PW-1:0]           psc;
    logic [COUNTER_SIZE-1:0] cnt;
    logic [COUNTER_SIZE-1:0] cnt_n;
    logic [COUNTER_SIZE-1:0] load_v;
    logic                    tick;
    logic                    bound;
    logic                    sat;
    logic                    wrap_gen;

`ifdef COUNTER_SAT_EN
    assign sat = bus.saturate;
`else
    assign sat = 1'b0;
`endif

    // Loads above the modulo range clamp to the top value.
    assign load_v = (bus.loadValue > MAXV) ? MAXV : bus.loadValue;

    always_comb begin
        tick     = bus.enable & ~bus.load & (psc == PSC_LAST);
        bound    = bus.countDirection ? (cnt == MAXV) : (cnt == '0);
        wrap_gen = 1'b0;
        cnt_n    = cnt;
        if (bound) begin
            if (!sat) begin
                cnt_n    = bus.countDirection ? '0 : MAXV;
                wrap_gen = tick;
            end
        end else if (bus.countDirection) begin
            cnt_n = cnt + COUNTER_SIZE'(1);
        end else begin
            cnt_n = cnt - COUNTER_SIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            psc      <= '0;
            bus.step <= 1'b0;
            bus.wrap <= 1'b0;
        end else if (bus.load) begin
            cnt      <= load_v;
            psc      <= '0;
            bus.step <= 1'b0;
            bus.wrap <= 1'b0;
        end else begin
            if (bus.enable)
                psc <= tick ? '0 : psc + PW'(1);
            if (tick)
                cnt <= cnt_n;
            bus.step <= tick;
            bus.wrap <= wrap_gen;
        end
    end

    // Set beats clear when both happen on the same edge.
    always_ff @(posedge clk) begin
        if (rst)
            bus.wrapFlag <= 1'b0;
        else if (wrap_gen)
            bus.wrapFlag <= 1'b1;
        else if (bus.clearWrap)
            bus.wrapFlag <= 1'b0;
    end

    assign bus.counterOut = cnt;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed testbench for updown_mod_counter.
// Three instances: MOD16/PSC1, MOD10/PSC1, MOD16/PSC4.
module tb_updown_mod_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    updown_mod_counter_if #(.COUNTER_SIZE(4)) b16 ();
    updown_mod_counter_if #(.COUNTER_SIZE(4)) b10 ();
    updown_mod_counter_if #(.COUNTER_SIZE(4)) b4 ();

    updown_mod_counter #(.COUNTER_SIZE(4), .MOD_VALUE(16), .PRESCALE(1))
        u16 (.clk(clk), .rst(rst), .bus(b16.slave));
    updown_mod_counter #(.COUNTER_SIZE(4), .MOD_VALUE(10), .PRESCALE(1))
        u10 (.clk(clk), .rst(rst), .bus(b10.slave));
    updown_mod_counter #(.COUNTER_SIZE(4), .MOD_VALUE(16), .PRESCALE(4))
        u4 (.clk(clk), .rst(rst), .bus(b4.slave));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        b16.enable = 0; b16.countDirection = 1; b16.load = 0;
        b16.loadValue = 0; b16.clearWrap = 0;
        b10.enable = 0; b10.countDirection = 1; b10.load = 0;
        b10.loadValue = 0; b10.clearWrap = 0;
        b4.enable = 0; b4.countDirection = 1; b4.load = 0;
        b4.loadValue = 0; b4.clearWrap = 0;
`ifdef COUNTER_SAT_EN
        b16.saturate = 0; b10.saturate = 0; b4.saturate = 0;
`endif

        // reset state
        rst = 1;
        cyc(1);
        rst = 0;
        chk("rst_cnt", b16.counterOut, 0);
        chk("rst_step", b16.step, 0);
        chk("rst_wrap", b16.wrap, 0);
        chk("rst_flag", b16.wrapFlag, 0);

        // MOD16 up for 17 clocks
        b16.enable = 1;
        for (int k = 1; k <= 17; k++) begin
            cyc(1);
            chk("t1_cnt", b16.counterOut, k % 16);
            chk("t1_wrap", b16.wrap, (k == 16) ? 1 : 0);
            chk("t1_step", b16.step, 1);
        end
        chk("t1_flag", b16.wrapFlag, 1);
        b16.enable = 0;

        // MOD10 down from 0: 9,8..0,9
        b10.enable = 1;
        b10.countDirection = 0;
        for (int k = 1; k <= 11; k++) begin
            cyc(1);
            chk("t2_cnt", b10.counterOut, (10 - (k % 10)) % 10);
            chk("t2_wrap", b10.wrap, (k % 10 == 1) ? 1 : 0);
        end
        b10.enable = 0;

        // PSC4: step every 4th enabled clock
        b4.enable = 1;
        for (int c = 1; c <= 8; c++) begin
            cyc(1);
            chk("t3_step", b4.step, (c % 4 == 0) ? 1 : 0);
            chk("t3_cnt", b4.counterOut, c / 4);
        end
        cyc(1);
        chk("t3_mid", b4.step, 0);
        b4.enable = 0;
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            chk("t3_hold_cnt", b4.counterOut, 2);
            chk("t3_hold_step", b4.step, 0);
        end
        b4.enable = 1;
        cyc(2);
        chk("t3_late_step", b4.step, 0);
        chk("t3_late_cnt", b4.counterOut, 2);
        cyc(1);
        chk("t3_resume_step", b4.step, 1);
        chk("t3_resume_cnt", b4.counterOut, 3);

        // run to 7, then reset mid-prescale
        cyc(16);
        chk("t5_at7", b4.counterOut, 7);
        cyc(2);
        rst = 1;
        cyc(1);
        rst = 0;
        chk("t5_rst_cnt", b4.counterOut, 0);
        chk("t5_rst_step", b4.step, 0);
        chk("t5_rst_wrap", b4.wrap, 0);
        chk("t5_rst_flag", b4.wrapFlag, 0);
        cyc(3);
        chk("t5_psc_clr", b4.step, 0);
        cyc(1);
        chk("t5_psc_step", b4.step, 1);
        chk("t5_psc_cnt", b4.counterOut, 1);
        b4.enable = 0;

        // MOD10 load clamp over a due tick
        b10.enable = 1;
        b10.countDirection = 1;
        b10.load = 1;
        b10.loadValue = 13;
        cyc(1);
        chk("t4_clamp", b10.counterOut, 9);
        chk("t4_wrap", b10.wrap, 0);
        chk("t4_step", b10.step, 0);
        b10.load = 0;
        cyc(1);
        chk("t4_up_cnt", b10.counterOut, 0);
        chk("t4_up_wrap", b10.wrap, 1);
        chk("t4_up_flag", b10.wrapFlag, 1);
        b10.load = 1;
        b10.loadValue = 5;
        cyc(1);
        chk("t4_load5", b10.counterOut, 5);
        b10.load = 0;
        cyc(1);
        chk("t4_after5", b10.counterOut, 6);

        // wrap set beats clear
        b10.load = 1;
        b10.loadValue = 0;
        cyc(1);
        b10.load = 0;
        b10.countDirection = 0;
        b10.clearWrap = 1;
        cyc(1);
        chk("t5_set_cnt", b10.counterOut, 9);
        chk("t5_set_wrap", b10.wrap, 1);
        chk("t5_set_flag", b10.wrapFlag, 1);
        b10.enable = 0;
        cyc(1);
        chk("t5_clr_flag", b10.wrapFlag, 0);
        chk("t5_clr_wrap", b10.wrap, 0);
        b10.clearWrap = 0;

`ifdef COUNTER_SAT_EN
        b16.clearWrap = 1;
        b16.load = 1;
        b16.loadValue = 15;
        cyc(1);
        b16.clearWrap = 0;
        b16.load = 0;
        b16.saturate = 1;
        b16.countDirection = 1;
        b16.enable = 1;
        cyc(1);
        chk("t6_hold", b16.counterOut, 15);
        chk("t6_step", b16.step, 1);
        chk("t6_wrap", b16.wrap, 0);
        chk("t6_flag", b16.wrapFlag, 0);
        b16.countDirection = 0;
        cyc(1);
        chk("t6_down", b16.counterOut, 14);
        b16.enable = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
